// File: rtl/mem_pkg.sv
// Shared memory-port definitions: access size codes, arbiter states and the
// lane helpers (byte enables, misalignment, load extract/extend).
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_ERR_D  = 2'd3
    } arb_state_e;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << off;
            SZ_HALF: be_gen = 4'b0011 << off;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic is_unsigned);
        logic [31:0] sh;
        logic        sgn;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: begin
                sgn      = sh[7] & ~is_unsigned;
                load_ext = {{24{sgn}}, sh[7:0]};
            end
            SZ_HALF: begin
                sgn      = sh[15] & ~is_unsigned;
                load_ext = {{16{sgn}}, sh[15:0]};
            end
            default: begin
                sgn      = 1'b0;
                load_ext = sh;
            end
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational data-port lane steering: byte enables, store shift,
// load extraction with sign/zero extension, misalignment detect.
module mem_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    assign be         = be_gen(size, off);
    assign wdata_sh   = wdata << {off, 3'b000};
    assign rdata_ext  = load_ext(rdata, size, off, is_unsigned);
    assign misaligned = is_misaligned(size, off);

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for a single-port memory bus, one transaction in
// flight. Optional bus-ack watchdog and i_err port: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic            i_err,
`endif
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [1:0]      d_size,
    input  logic            d_unsigned,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    arb_state_e      state_q, state_d;
    logic [3:0]      streak_q, streak_d;
    logic            i_gnt_q, i_gnt_d, i_rvalid_q, i_rvalid_d;
    logic [XLEN-1:0] i_rdata_q, i_rdata_d;
    logic            d_gnt_q, d_gnt_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [1:0]      d_size_q, d_size_d, d_off_q, d_off_d;
    logic            d_uns_q, d_uns_d;

    logic [1:0]      steer_size_s, steer_off_s;
    logic            steer_uns_s, misal_s, tmo_hit_s, unused_s;
    logic [3:0]      st_be_s;
    logic [XLEN-1:0] st_wdata_s, ld_data_s;

    assign unused_s = ^i_addr[1:0];

    // In IDLE the live request is steered; while busy the captured access shapes the load.
    assign steer_size_s = (state_q == ST_IDLE) ? d_size     : d_size_q;
    assign steer_off_s  = (state_q == ST_IDLE) ? d_addr[1:0] : d_off_q;
    assign steer_uns_s  = (state_q == ST_IDLE) ? d_unsigned : d_uns_q;

    mem_lane_steer u_steer (
        .size        (steer_size_s),
        .off         (steer_off_s),
        .is_unsigned (steer_uns_s),
        .wdata       (d_wdata),
        .rdata       (bus_rdata),
        .be          (st_be_s),
        .wdata_sh    (st_wdata_s),
        .rdata_ext   (ld_data_s),
        .misaligned  (misal_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          i_err_q, i_err_d;

    assign tmo_hit_s = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign i_err     = i_err_q;

    // Watchdog: counts busy cycles without an ack.
    always_comb begin
        if (((state_q == ST_BUSY_I) || (state_q == ST_BUSY_D)) && !bus_ack) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = {TW{1'b0}};
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= {TW{1'b0}};
            i_err_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            i_err_q   <= i_err_d;
        end
    end
`else
    logic unused_tmo_s;
    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = (TIMEOUT > 0);
`endif

    // Arbitration, issue and completion: next state and all registered outputs.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        i_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = {XLEN{1'b0}};
        d_gnt_d     = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = {XLEN{1'b0}};
        d_err_d     = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        d_size_d    = d_size_q;
        d_off_d     = d_off_q;
        d_uns_d     = d_uns_q;
`ifdef MEM_ARB_TIMEOUT_EN
        i_err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (d_req && !(i_req && (streak_q == MAX_STREAK))) begin
                    d_gnt_d  = 1'b1;
                    if (i_req) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                    d_size_d = d_size;
                    d_off_d  = d_addr[1:0];
                    d_uns_d  = d_unsigned;
                    if (misal_s) begin
                        state_d = ST_ERR_D;
                    end else begin
                        state_d     = ST_BUSY_D;
                        bus_req_d   = 1'b1;
                        bus_we_d    = d_we;
                        bus_addr_d  = {d_addr[XLEN-1:2], 2'b00};
                        bus_wdata_d = st_wdata_s;
                        bus_be_d    = st_be_s;
                    end
                end else if (i_req) begin
                    i_gnt_d     = 1'b1;
                    streak_d    = 4'd0;
                    state_d     = ST_BUSY_I;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {i_addr[XLEN-1:2], 2'b00};
                    bus_wdata_d = {XLEN{1'b0}};
                    bus_be_d    = 4'hF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (bus_ack || tmo_hit_s) begin
                    state_d     = ST_IDLE;
                    i_rvalid_d  = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {XLEN{1'b0}};
                    bus_wdata_d = {XLEN{1'b0}};
                    bus_be_d    = 4'h0;
                    if (bus_ack) begin
                        i_rdata_d = bus_rdata;
                    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                        i_err_d   = 1'b1;
`endif
                        i_rdata_d = {XLEN{1'b0}};
                    end
                end else begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                if (bus_ack || tmo_hit_s) begin
                    state_d     = ST_IDLE;
                    d_rvalid_d  = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {XLEN{1'b0}};
                    bus_wdata_d = {XLEN{1'b0}};
                    bus_be_d    = 4'h0;
                    if (bus_ack && !bus_we_q) begin
                        d_rdata_d = ld_data_s;
                    end else begin
                        d_rdata_d = {XLEN{1'b0}};
                    end
                    d_err_d = !bus_ack;
                end else begin
                    state_d = ST_BUSY_D;
                end
            end
            ST_ERR_D: begin
                state_d    = ST_IDLE;
                d_rvalid_d = 1'b1;
                d_err_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= 4'd0;
            i_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= {XLEN{1'b0}};
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= {XLEN{1'b0}};
            d_err_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {XLEN{1'b0}};
            bus_wdata_q <= {XLEN{1'b0}};
            bus_be_q    <= 4'h0;
            d_size_q    <= 2'd0;
            d_off_q     <= 2'd0;
            d_uns_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            i_gnt_q     <= i_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            d_size_q    <= d_size_d;
            d_off_q     <= d_off_d;
            d_uns_q     <= d_uns_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: lane vector table, scoreboarded bus and
// response queues, plus hand sequences for arbitration, starvation and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        i_err;
`endif
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
`ifdef MEM_ARB_TIMEOUT_EN
        .i_err(i_err),
`endif
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_exp_t;
    typedef struct packed {logic err; logic [31:0] rdata;} d_exp_t;
    typedef struct {logic who; int cyc;} gl_t;
    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; logic uns;
        logic [31:0] rsp; logic uses_bus; logic [31:0] ebaddr; logic [3:0] ebe;
        logic [31:0] ebwdata; logic [31:0] erdata; logic eerr;
    } vec_t;

    bus_exp_t    exp_bus[$];
    d_exp_t      exp_d[$];
    logic [31:0] exp_i[$];
    gl_t         gnt_log[$];
    vec_t        vecs[12];

    int total = 0, bad = 0, cyc = 0, bus_starts = 0, d_rv_count = 0, last_d_rv_cyc = 0;
    int bus_lat = 0;
    logic bus_chk = 1'b1, rsp_en = 1'b1, force_ack = 1'b0, bus_req_prev = 1'b0;
    logic [31:0] rsp_word = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns);
        bit seen = 1'b0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_unsigned = uns;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = d_gnt;
        end
        if (!seen) note_fail("d_gnt_timeout");
        tick();
        d_req = 1'b0;
    endtask

    task automatic i_access(input logic [31:0] addr);
        bit seen = 1'b0;
        i_req = 1'b1; i_addr = addr;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = i_gnt;
        end
        if (!seen) note_fail("i_gnt_timeout");
        tick();
        i_req = 1'b0;
    endtask

    task automatic d_stream(input int count);
        int got = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h240; d_size = 2'd2; d_unsigned = 1'b0;
        for (int n = 0; n < 300 && got < count; n++) begin
            @(negedge clk);
            if (d_gnt) got++;
        end
        if (got != count) note_fail("d_stream_timeout");
        tick();
        d_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            done = (exp_bus.size() == 0) && (exp_d.size() == 0) && (exp_i.size() == 0);
            if (!done) @(negedge clk);
        end
        if (!done) note_fail("wait_idle_timeout");
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {22'd0, bus_req, bus_we, bus_be, i_gnt, i_rvalid, d_gnt, d_rvalid}, 32'd0);
        chk({name, "_err"}, {31'd0, d_err}, 32'd0);
        chk({name, "_baddr"}, bus_addr, 32'd0);
        chk({name, "_bwdata"}, bus_wdata, 32'd0);
        chk({name, "_irdata"}, i_rdata, 32'd0);
        chk({name, "_drdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
        d_wdata = 32'h0; d_size = 2'd0; d_unsigned = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;

        vecs[0]  = '{1'b1, 32'h203, 32'h000000AB, 2'd0, 1'b0, 32'h0,        1'b1, 32'h200, 4'b1000, 32'hAB000000, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h202, 32'h0,        2'd1, 1'b0, 32'h80011234, 1'b1, 32'h200, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[2]  = '{1'b0, 32'h202, 32'h0,        2'd1, 1'b1, 32'h80011234, 1'b1, 32'h200, 4'b1100, 32'h0,        32'h00008001, 1'b0};
        vecs[3]  = '{1'b0, 32'h200, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h200, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h201, 32'h0,        2'd0, 1'b0, 32'h12348056, 1'b1, 32'h200, 4'b0010, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, 32'h202, 32'h0,        2'd0, 1'b1, 32'h12348056, 1'b1, 32'h200, 4'b0100, 32'h0,        32'h00000034, 1'b0};
        vecs[6]  = '{1'b1, 32'h206, 32'h12345678, 2'd1, 1'b0, 32'h0,        1'b1, 32'h204, 4'b1100, 32'h56780000, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h20C, 32'hCAFEF00D, 2'd3, 1'b0, 32'h0,        1'b1, 32'h20C, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h201, 32'h0,        2'd2, 1'b0, 32'h0,        1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h203, 32'h00001234, 2'd1, 1'b0, 32'h0,        1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h203, 32'h0,        2'd0, 1'b0, 32'h7F000000, 1'b1, 32'h200, 4'b1000, 32'h0,        32'h0000007F, 1'b0};
        vecs[11] = '{1'b0, 32'h200, 32'h0,        2'd1, 1'b0, 32'hFFFF8765, 1'b1, 32'h200, 4'b0011, 32'h0,        32'hFFFF8765, 1'b0};

        fork
            // Output monitor: scoreboard pops and grant log.
            forever begin
                bus_exp_t be_e;
                d_exp_t   de;
                @(negedge clk);
                cyc++;
                if (bus_req === 1'b1 && bus_req_prev !== 1'b1) begin
                    bus_starts++;
                    if (bus_chk) begin
                        if (exp_bus.size() == 0) note_fail("bus_unexpected");
                        else begin
                            be_e = exp_bus.pop_front();
                            chk("bus_addr", bus_addr, be_e.addr);
                            chk("bus_we", {31'd0, bus_we}, {31'd0, be_e.we});
                            chk("bus_be", {28'd0, bus_be}, {28'd0, be_e.be});
                            chk("bus_wdata", bus_wdata, be_e.wdata);
                        end
                    end
                end
                bus_req_prev = bus_req;
                if (d_rvalid === 1'b1) begin
                    d_rv_count++;
                    last_d_rv_cyc = cyc;
                    if (exp_d.size() == 0) note_fail("d_rvalid_unexpected");
                    else begin
                        de = exp_d.pop_front();
                        chk("d_rdata", d_rdata, de.rdata);
                        chk("d_err", {31'd0, d_err}, {31'd0, de.err});
                    end
                end
                if (i_rvalid === 1'b1) begin
                    if (exp_i.size() == 0) note_fail("i_rvalid_unexpected");
                    else chk("i_rdata", i_rdata, exp_i.pop_front());
                end
                if (d_gnt === 1'b1 || i_gnt === 1'b1) begin
                    chk("single_gnt", {31'd0, d_gnt & i_gnt}, 32'd0);
                    gnt_log.push_back('{i_gnt, cyc});
                end
            end
            // Bus responder with programmable ack latency.
            begin
                int wcnt = 0;
                bit done = 1'b0;
                forever begin
                    tick();
                    bus_ack = 1'b0;
                    if (force_ack) begin
                        bus_ack = 1'b1;
                        bus_rdata = rsp_word;
                    end else if (bus_req !== 1'b1) begin
                        wcnt = 0;
                        done = 1'b0;
                    end else if (!done && rsp_en) begin
                        if (wcnt == bus_lat) begin
                            bus_ack = 1'b1;
                            bus_rdata = rsp_word;
                            done = 1'b1;
                        end else begin
                            wcnt++;
                        end
                    end else begin
                        bus_ack = 1'b0;
                    end
                end
            end
            // Stimulus.
            begin
                int s0, g0;
                logic exp_who[11];
                exp_who = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

                repeat (2) @(posedge clk);
                @(negedge clk);
                chk_all_zero("reset");
                tick();
                rst = 1'b0;

                // Fetch with one wait cycle: gnt in cycle 1, rvalid in cycle 3.
                bus_lat = 1;
                rsp_word = 32'h00500093;
                exp_bus.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
                exp_i.push_back(32'h00500093);
                i_req = 1'b1; i_addr = 32'h102;
                tick();
                @(negedge clk);
                chk("fetch_gnt_c1", {31'd0, i_gnt}, 32'd1);
                tick();
                i_req = 1'b0;
                @(negedge clk);
                chk("fetch_rv_c2", {31'd0, i_rvalid}, 32'd0);
                @(negedge clk);
                chk("fetch_rv_c3", {31'd0, i_rvalid}, 32'd1);
                wait_idle();

                // Lane table.
                for (int k = 0; k < 12; k++) begin
                    bus_lat = k % 2;
                    rsp_word = vecs[k].rsp;
                    if (vecs[k].uses_bus)
                        exp_bus.push_back('{vecs[k].we, vecs[k].ebaddr, vecs[k].ebwdata, vecs[k].ebe});
                    exp_d.push_back('{vecs[k].eerr, vecs[k].erdata});
                    s0 = bus_starts;
                    d_access(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].size, vecs[k].uns);
                    wait_idle();
                    if (!vecs[k].uses_bus) chk("misal_no_bus", bus_starts, s0);
                end

                // Simultaneous requests: D first, I two cycles later.
                bus_chk = 1'b0; bus_lat = 0; rsp_word = 32'h11112222;
                gnt_log.delete();
                exp_d.push_back('{1'b0, 32'h11112222});
                exp_i.push_back(32'h11112222);
                fork
                    d_access(1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
                    i_access(32'h104);
                join
                wait_idle();
                chk("simul_len", gnt_log.size(), 32'd2);
                if (gnt_log.size() == 2) begin
                    chk("simul_first_d", {31'd0, gnt_log[0].who}, 32'd0);
                    chk("simul_second_i", {31'd0, gnt_log[1].who}, 32'd1);
                    chk("simul_gap", gnt_log[1].cyc - gnt_log[0].cyc, 32'd2);
                end

                // Starvation: D held, two fetches pending.
                gnt_log.delete();
                rsp_word = 32'h0BADF00D;
                for (int k = 0; k < 9; k++) exp_d.push_back('{1'b0, 32'h0BADF00D});
                exp_i.push_back(32'h0BADF00D);
                exp_i.push_back(32'h0BADF00D);
                fork
                    d_stream(9);
                    begin
                        i_access(32'h108);
                        i_access(32'h10C);
                    end
                join
                wait_idle();
                chk("starve_len", gnt_log.size(), 32'd11);
                for (int k = 0; k < 11 && k < gnt_log.size(); k++)
                    chk($sformatf("starve_who%0d", k), {31'd0, gnt_log[k].who}, {31'd0, exp_who[k]});

                // Reset while BUSY_D, ack one cycle after reset.
                bus_chk = 1'b1; rsp_en = 1'b0; rsp_word = 32'h55555555;
                exp_bus.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
                s0 = d_rv_count;
                d_access(1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                force_ack = 1'b1;
                @(negedge clk);
                chk_all_zero("midrst");
                tick();
                force_ack = 1'b0;
                repeat (4) @(negedge clk);
                chk("midrst_no_rvalid", d_rv_count, s0);
                tick();
                rsp_en = 1'b1; rsp_word = 32'h13579BDF;
                exp_bus.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
                exp_d.push_back('{1'b0, 32'h13579BDF});
                d_access(1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
                wait_idle();

`ifdef MEM_ARB_TIMEOUT_EN
                // Watchdog: no ack, error response 64 cycles after grant.
                rsp_en = 1'b0;
                gnt_log.delete();
                exp_bus.push_back('{1'b0, 32'h400, 32'h0, 4'hF});
                exp_d.push_back('{1'b1, 32'h0});
                d_access(1'b0, 32'h400, 32'h0, 2'd2, 1'b0);
                wait_idle();
                g0 = (gnt_log.size() > 0) ? gnt_log[0].cyc : 0;
                chk("tmo_latency", last_d_rv_cyc - g0, 32'd64);
                rsp_en = 1'b1;
`else
                g0 = 0;
`endif
                repeat (3) tick();
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory bus between the fetch stage (instruction port I) and the memory stage (data port D). One transaction is outstanding at a time, with a req/gnt/rvalid handshake on each requester side and a req/ack handshake on the bus side, so the bus may have variable latency. Data-port lane steering (byte enables, store shifting, load extraction and sign extension) lives here, so fetch and memory need no alignment logic.

Parameters:
XLEN, 32, data/address width (only 32 supported)
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting (1..15)
TIMEOUT, 64, bus-ack watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request; held until i_gnt
i_addr  in  XLEN  fetch address; word aligned, bits [1:0] ignored
i_gnt  out  1  one-cycle pulse: request accepted, requester may drop i_req
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  XLEN  instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store
d_addr  in  XLEN  byte address
d_wdata  in  XLEN  store data, in the LSBs
d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
d_unsigned  in  1  zero-extend loads
d_gnt  out  1  one-cycle accept pulse
d_rvalid  out  1  one-cycle completion pulse (loads and stores)
d_rdata  out  XLEN  extended load data; 0 on stores and errors
d_err  out  1  valid with d_rvalid: misaligned access or timeout
bus_req  out  1  held high from issue until the ack cycle
bus_we  out  1  write strobe
bus_addr  out  XLEN  word address; bits [1:0] = 0
bus_wdata  out  XLEN  lane-shifted store data
bus_be  out  4  byte enables
bus_ack  in  1  single-cycle completion from memory
bus_rdata  in  XLEN  read word; valid with bus_ack

Behaviour:
- FSM states:
  - IDLE: arbitrate.
  - BUSY_I: bus owned by I, waiting for bus_ack.
  - BUSY_D: bus owned by D, waiting for bus_ack.
  - ERR_D: one-cycle state that returns a misaligned D access without touching the bus.
- Reset:
  - State goes to IDLE and the streak counter clears.
  - All outputs are driven 0, including bus_req, i_gnt, i_rvalid, d_gnt, d_rvalid and d_err.
- Reset mid-transaction: bus_req drops on the next edge, the in-flight bus_ack is ignored, and no rvalid is produced.
- Arbitration (IDLE, on a clock edge):
  - If d_req is high, D wins, unless i_req is also high and the streak equals MAX_D_STREAK; then I wins.
  - If only i_req is high, I wins.
- Streak counter:
  - Increments on a D grant while i_req is high.
  - Clears on an I grant, or on a D grant while i_req is low.
- Grant: all outputs are registered. For a request seen at edge N:
  - gnt is high during cycle N+1.
  - bus_req, bus_addr, bus_we, bus_wdata and bus_be are valid from cycle N+1.
- Completion:
  - bus_ack sampled at edge M gives rvalid during cycle M+1, and bus_req is low in cycle M+1.
  - The FSM returns to IDLE at edge M and may arbitrate again at edge M+1.
  - Zero-wait memory gives 2 cycles per transaction.
- Misalignment:
  - Defined as half with addr[0]=1, or word with addr[1:0]!=0.
  - Path is ERR_D, then d_gnt plus d_rvalid with d_err=1, and d_rdata=0.
  - No bus cycle occurs and the streak still updates.
- Data-port lanes:
  - bus_be: byte = 1<<a; half = 3<<a; word = 4'hF, where a = addr[1:0].
  - bus_wdata = d_wdata << 8a.
  - Load data is bus_rdata >> 8a, truncated to the access size, then sign- or zero-extended per d_unsigned.
- Instruction reads use bus_be = 4'hF and bus_we = 0.
- Inputs are ignored outside IDLE, so a requester is never granted twice for one held req.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined: a cycle counter runs in BUSY_I and BUSY_D.
  - If TIMEOUT cycles pass without bus_ack, bus_req drops and the owner gets rvalid with rdata=0.
  - On D this also sets d_err=1; on I it also pulses an added output port i_err.
  - A late bus_ack arriving in IDLE is ignored.
- Undefined: no counter and no i_err port; the block waits for bus_ack indefinitely.

Decomposition:
- Shared package (mem_pkg) holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the arbiter state enum;
  - the BE-generation and load-extension functions, which the memory stage reuses.
- One natural sub-module, mem_lane_steer: purely combinational BE, store shift and load extract/extend. The FSM stays in mem_arbiter.

Test Plan:
- I-only fetch: i_req with 0x100, bus acks 1 cycle later with 0x00500093 -> i_gnt in cycle 1, i_rvalid with i_rdata=0x00500093 in cycle 3, bus_addr=0x100, bus_be=F.
- Simultaneous req: D load word 0x200 plus I 0x104 -> D granted first, I granted 2 cycles later.
- Starvation: d_req held continuously with i_req pending -> after 4 D grants the 5th grant goes to I; streak then clears.
- Lanes:
  - store byte 0xAB at 0x203 -> bus_be=1000, bus_wdata=0xAB000000;
  - load half signed at 0x202 with bus_rdata 0x8001xxxx -> d_rdata=0xFFFF8001, and with d_unsigned -> 0x00008001.
- Misaligned word load at 0x201 -> bus_req never rises; d_rvalid and d_err=1 with d_rdata=0.
- rst asserted while BUSY_D, with the ack arriving one cycle later -> no d_rvalid, all outputs 0, next request served normally. With MEM_ARB_TIMEOUT_EN and no ack -> d_err after 64 cycles.
